spi_display_regs: RTL and testbench

//   Upstream stage of the video generator: receives SPI command packets from the

---
 rtl/spi_display_regs_if.sv | 14 +
 rtl/spi_display_regs.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_display_regs.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_display_regs_if.sv
// SPI link from the game MCU into the display register block.
//   sck   : SPI clock (mode 0; data is sampled on the rising edge)
//   mosi  : serial data, MSB first
//   cs_b  : active-low chip select that frames one packet
// The master modport drives the bus (MCU side, or a testbench).
// The slave modport is the receiver inside spi_display_regs.
interface spi_display_regs_if;
  logic sck;
  logic mosi;
  logic cs_b;

  modport master (output sck, output mosi, output cs_b);
  modport slave  (input  sck, input  mosi, input  cs_b);
endinterface

// File: rtl/spi_display_regs.sv
// spi_display_regs
// Receives SPI command packets from the game MCU and writes them into a shadow
// register file of display state. The shadow is copied to the outputs once per
// frame, on the falling edge of vsync, so that the picture never tears.
// Ports:
//   vgaclk      in   pixel clock; the only clock in this module
//   reset_b     in   asynchronous active-low reset
//   spi         in   SPI bus (sck/mosi/cs_b); asynchronous to vgaclk
//   vsync       in   active-low vsync, already in the vgaclk domain
//   hp1, hp2    out  health-bar lengths, saturated at HP_MAX
//   sprite_sel1 out  main sprite index for player 1
//   sprite_sel2 out  main sprite index for player 2
//   cursor      out  selected move slot
//   screen_mode out  0 battle, 1 switch, 2 message, 3 reserved
//   pkt_err     out  sticky framing/address error flag (not frame-latched)
//   leds        out  last complete byte received (not frame-latched)
// Packet format: the first byte is an address (bits 7:3 must be zero). Each
// following byte writes shadow[ptr], and ptr then increments and wraps from 7
// to 0. Register 7 is a strobe that clears pkt_err.
module spi_display_regs #(
  parameter int SYNC_STAGES = 2,
  parameter int HP_MAX      = 100,
  parameter int HP_RESET    = 100
) (
  input  logic                vgaclk,
  input  logic                reset_b,
  spi_display_regs_if.slave   spi,
  input  logic                vsync,
  output logic [6:0]          hp1,
  output logic [6:0]          hp2,
  output logic [3:0]          sprite_sel1,
  output logic [3:0]          sprite_sel2,
  output logic [1:0]          cursor,
  output logic [1:0]          screen_mode,
  output logic                pkt_err,
  output logic [7:0]          leds
);

  localparam logic [7:0] HP_MAX_B   = 8'(HP_MAX);
  localparam logic [6:0] HP_MAX_7   = 7'(HP_MAX);
  localparam logic [6:0] HP_RESET_7 = 7'(HP_RESET);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // Synchroniser chains. Bit order is {cs_b, mosi, sck}.
  // Each chain resets to the idle bus level (cs_b high, sck low).
  logic [2:0] raw_in;
  logic [2:0] sync_q [SYNC_STAGES];
  assign raw_in = {spi.cs_b, spi.mosi, spi.sck};

  logic sck_s, mosi_s, cs_s;
  assign sck_s  = sync_q[SYNC_STAGES-1][0];
  assign mosi_s = sync_q[SYNC_STAGES-1][1];
  assign cs_s   = sync_q[SYNC_STAGES-1][2];

  // Registered state and its next-state values.
  state_t     state_q, state_d;
  logic       sck_prev_q, cs_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] ptr_q, ptr_d;
  logic       ignore_q, ignore_d;     // address error: drop bytes until cs_b rises
  logic       vsync_q, vsync_prev_q;
  logic       pkt_err_q, pkt_err_d;
  logic [7:0] leds_q, leds_d;

  logic [6:0] hp1_sh_q, hp1_sh_d, hp2_sh_q, hp2_sh_d;
  logic [3:0] spr1_sh_q, spr1_sh_d, spr2_sh_q, spr2_sh_d;
  logic [1:0] cur_sh_q, cur_sh_d, mode_sh_q, mode_sh_d;

  logic [6:0] hp1_q, hp1_d, hp2_q, hp2_d;
  logic [3:0] spr1_q, spr1_d, spr2_q, spr2_d;
  logic [1:0] cur_q, cur_d, mode_q, mode_d;

  // Decoded events for the current cycle.
  logic       sck_rise, cs_rise, byte_done, commit;
  logic       wr_en, err_set, err_clr;
  logic [7:0] rx_byte;
  logic [6:0] hp_sat;

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // cs_b high dominates: a byte that completes as cs_b deasserts is dropped.
  assign byte_done = ~cs_s & sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q, mosi_s};
  assign hp_sat    = (rx_byte > HP_MAX_B) ? HP_MAX_7 : rx_byte[6:0];
  // Commit fires on a 1->0 transition of the registered vsync.
  assign commit    = vsync_prev_q & ~vsync_q;

  // Next-state logic for the FSM and the datapath.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ignore_d  = ignore_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;

    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = rx_byte[6:0];
    end

    // A packet that ends mid-byte is a framing error.
    if (cs_rise && (bit_cnt_q != 3'd0)) err_set = 1'b1;

    if (cs_s) begin
      state_d  = IDLE;
      ignore_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (!ignore_q) state_d = ADDR;
        ADDR: if (byte_done) begin
          if (rx_byte[7:3] != 5'd0) begin
            err_set  = 1'b1;
            ignore_d = 1'b1;
            state_d  = IDLE;
          end else begin
            ptr_d   = rx_byte[2:0];
            state_d = DATA;
          end
        end
        DATA: if (byte_done) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end

    hp1_sh_d  = hp1_sh_q;
    hp2_sh_d  = hp2_sh_q;
    spr1_sh_d = spr1_sh_q;
    spr2_sh_d = spr2_sh_q;
    cur_sh_d  = cur_sh_q;
    mode_sh_d = mode_sh_q;
    if (wr_en) begin
      unique case (ptr_q)
        3'd0: hp1_sh_d  = hp_sat;
        3'd1: hp2_sh_d  = hp_sat;
        3'd2: spr1_sh_d = rx_byte[3:0];
        3'd3: spr2_sh_d = rx_byte[3:0];
        3'd4: cur_sh_d  = rx_byte[1:0];
        3'd5: mode_sh_d = rx_byte[1:0];
        3'd7: err_clr   = 1'b1;
        default: ;  // slot 6 is reserved and silently ignored
      endcase
    end

    // A new error beats a same-cycle clear.
    pkt_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : pkt_err_q);
    leds_d    = byte_done ? rx_byte : leds_q;

    // The commit reads the shadow registers before this cycle's write lands,
    // so a write that completes on the commit cycle appears at the next frame.
    hp1_d  = commit ? hp1_sh_q  : hp1_q;
    hp2_d  = commit ? hp2_sh_q  : hp2_q;
    spr1_d = commit ? spr1_sh_q : spr1_q;
    spr2_d = commit ? spr2_sh_q : spr2_q;
    cur_d  = commit ? cur_sh_q  : cur_q;
    mode_d = commit ? mode_sh_q : mode_q;
  end

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // FSM state register.
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      ptr_q        <= 3'd0;
      ignore_q     <= 1'b0;
      vsync_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
      pkt_err_q    <= 1'b0;
      leds_q       <= 8'd0;
      hp1_sh_q     <= HP_RESET_7;
      hp2_sh_q     <= HP_RESET_7;
      spr1_sh_q    <= 4'd1;
      spr2_sh_q    <= 4'd2;
      cur_sh_q     <= 2'd0;
      mode_sh_q    <= 2'd0;
      hp1_q        <= HP_RESET_7;
      hp2_q        <= HP_RESET_7;
      spr1_q       <= 4'd1;
      spr2_q       <= 4'd2;
      cur_q        <= 2'd0;
      mode_q       <= 2'd0;
    end else begin
      sck_prev_q   <= sck_s;
      cs_prev_q    <= cs_s;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      ignore_q     <= ignore_d;
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
      pkt_err_q    <= pkt_err_d;
      leds_q       <= leds_d;
      hp1_sh_q     <= hp1_sh_d;
      hp2_sh_q     <= hp2_sh_d;
      spr1_sh_q    <= spr1_sh_d;
      spr2_sh_q    <= spr2_sh_d;
      cur_sh_q     <= cur_sh_d;
      mode_sh_q    <= mode_sh_d;
      hp1_q        <= hp1_d;
      hp2_q        <= hp2_d;
      spr1_q       <= spr1_d;
      spr2_q       <= spr2_d;
      cur_q        <= cur_d;
      mode_q       <= mode_d;
    end
  end

  assign hp1         = hp1_q;
  assign hp2         = hp2_q;
  assign sprite_sel1 = spr1_q;
  assign sprite_sel2 = spr2_q;
  assign cursor      = cur_q;
  assign screen_mode = mode_q;
  assign pkt_err     = pkt_err_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_spi_display_regs.sv
// Testbench for spi_display_regs. Drives SPI packets and vsync pulses.
// A reference model of the shadow registers tracks every write. At each vsync,
// a snapshot of the model is queued; it is popped and compared when the
// frame-latched outputs update. pkt_err and leds are compared directly.
module tb_spi_display_regs;

  typedef struct packed {
    logic [6:0] hp1;
    logic [6:0] hp2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] cur;
    logic [1:0] mode;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       vsync;
  logic [6:0] hp1, hp2;
  logic [3:0] sprite_sel1, sprite_sel2;
  logic [1:0] cursor, screen_mode;
  logic       pkt_err;
  logic [7:0] leds;

  spi_display_regs_if spi_bus ();

  spi_display_regs #(.SYNC_STAGES(2), .HP_MAX(100), .HP_RESET(100)) dut (
    .vgaclk      (clk),
    .reset_b     (reset_b),
    .spi         (spi_bus.slave),
    .vsync       (vsync),
    .hp1         (hp1),
    .hp2         (hp2),
    .sprite_sel1 (sprite_sel1),
    .sprite_sel2 (sprite_sel2),
    .cursor      (cursor),
    .screen_mode (screen_mode),
    .pkt_err     (pkt_err),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  snap_t m_sh;        // model shadow registers
  snap_t c_snap;      // model of the currently committed outputs
  logic  m_err;
  logic  m_ign;
  logic [7:0] m_leds;
  logic [2:0] m_ptr;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: b is byte number idx of the current packet.
  task automatic model_byte(input int idx, input logic [7:0] b);
    m_leds = b;
    if (idx == 0) begin
      if (b[7:3] != 5'd0) begin
        m_err = 1'b1;
        m_ign = 1'b1;
      end else begin
        m_ptr = b[2:0];
      end
    end else if (!m_ign) begin
      case (m_ptr)
        3'd0: m_sh.hp1  = (b > 8'd100) ? 7'd100 : b[6:0];
        3'd1: m_sh.hp2  = (b > 8'd100) ? 7'd100 : b[6:0];
        3'd2: m_sh.s1   = b[3:0];
        3'd3: m_sh.s2   = b[3:0];
        3'd4: m_sh.cur  = b[1:0];
        3'd5: m_sh.mode = b[1:0];
        3'd7: m_err     = 1'b0;
        default: ;
      endcase
      m_ptr = m_ptr + 3'd1;
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_bus.mosi = b;
    tick(4);
    spi_bus.sck = 1'b1;
    tick(4);
    spi_bus.sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic send_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    logic [7:0] bytes [5];
    bytes = '{b0, b1, b2, b3, b4};
    m_ign = 1'b0;
    spi_bus.cs_b = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      spi_byte(bytes[i]);
      model_byte(i, bytes[i]);
    end
    tick(4);
    spi_bus.cs_b = 1'b1;
    tick(8);
    $display("packet n=%0d first=%02h pkt_err=%0d leds=%02h", n, b0, pkt_err, leds);
  endtask

  task automatic check_old();
    check("pre_hp1", int'(hp1), int'(c_snap.hp1));
    check("pre_hp2", int'(hp2), int'(c_snap.hp2));
  endtask

  task automatic pop_check();
    snap_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("hp1", int'(hp1), int'(e.hp1));
      check("hp2", int'(hp2), int'(e.hp2));
      check("sprite_sel1", int'(sprite_sel1), int'(e.s1));
      check("sprite_sel2", int'(sprite_sel2), int'(e.s2));
      check("cursor", int'(cursor), int'(e.cur));
      check("screen_mode", int'(screen_mode), int'(e.mode));
      c_snap = e;
      $display("commit hp1=%0d hp2=%0d s1=%0d s2=%0d cur=%0d mode=%0d",
               hp1, hp2, sprite_sel1, sprite_sel2, cursor, screen_mode);
    end
  endtask

  // vsync falls; outputs must hold for one cycle, then show the snapshot.
  task automatic do_commit();
    exp_q.push_back(m_sh);
    vsync = 1'b0;
    tick(1);
    check_old();
    tick(1);
    pop_check();
    vsync = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [7:0] late_b;
    reset_b = 1'b0;
    vsync = 1'b1;
    spi_bus.cs_b = 1'b1;
    spi_bus.sck = 1'b0;
    spi_bus.mosi = 1'b0;
    m_sh = '{hp1: 7'd100, hp2: 7'd100, s1: 4'd1, s2: 4'd2, cur: 2'd0, mode: 2'd0};
    c_snap = m_sh;
    m_err = 1'b0;
    m_ign = 1'b0;
    m_leds = 8'd0;
    m_ptr = 3'd0;
    tick(3);
    reset_b = 1'b1;
    tick(2);

    // Reset state, then three idle frames.
    check("rst_hp1", int'(hp1), 100);
    check("rst_hp2", int'(hp2), 100);
    check("rst_s1", int'(sprite_sel1), 1);
    check("rst_s2", int'(sprite_sel2), 2);
    check("rst_cur", int'(cursor), 0);
    check("rst_mode", int'(screen_mode), 0);
    check("rst_err", int'(pkt_err), 0);
    check("rst_leds", int'(leds), 0);
    repeat (3) begin
      do_commit();
      check("idle_err", int'(pkt_err), 0);
    end

    // Set hp1 to 50.
    send_pkt(2, 8'h00, 8'h32, 8'h00, 8'h00, 8'h00);
    check("t2_leds", int'(leds), int'(m_leds));
    check("t2_hold", int'(hp1), 100);
    do_commit();

    // Burst write to sprite, cursor and mode registers.
    send_pkt(5, 8'h02, 8'h05, 8'h07, 8'h03, 8'h01);
    do_commit();

    // Saturate hp2, then write zero.
    send_pkt(2, 8'h01, 8'hC8, 8'h00, 8'h00, 8'h00);
    do_commit();
    send_pkt(2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    do_commit();

    // Partial byte gives a framing error.
    spi_bus.cs_b = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    tick(4);
    spi_bus.cs_b = 1'b1;
    tick(8);
    m_err = 1'b1;
    check("t5_partial_err", int'(pkt_err), int'(m_err));
    check("t5_partial_leds", int'(leds), int'(m_leds));
    send_pkt(2, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
    check("t5_clear", int'(pkt_err), int'(m_err));
    send_pkt(2, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00);
    check("t5_addr_err", int'(pkt_err), int'(m_err));
    do_commit();

    // Burst with pointer wrap: clear the error, then write hp1=1.
    send_pkt(3, 8'h07, 8'h00, 8'h01, 8'h00, 8'h00);
    check("t6_wrap_err", int'(pkt_err), int'(m_err));
    do_commit();

    // A data byte completes on the exact commit cycle.
    late_b = 8'h0A;
    m_ign = 1'b0;
    spi_bus.cs_b = 1'b0;
    tick(4);
    spi_byte(8'h00);
    model_byte(0, 8'h00);
    exp_q.push_back(m_sh);
    for (int i = 7; i >= 1; i--) spi_bit(late_b[i]);
    spi_bus.mosi = late_b[0];
    tick(4);
    spi_bus.sck = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
    check_old();
    tick(1);
    pop_check();
    vsync = 1'b1;
    spi_bus.sck = 1'b0;
    model_byte(1, late_b);
    tick(8);
    spi_bus.cs_b = 1'b1;
    tick(8);
    check("t6_late_leds", int'(leds), int'(m_leds));
    do_commit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
